decode_stage_q: RTL and testbench



---
 rtl/decode_stage_q_pkg.sv | 94 +++++++++
 rtl/decode_stage_q_fifo.sv | 73 +++++++
 rtl/decode_stage_q.sv | 248 ++++++++++++++++++++++++
 tb/tb_decode_stage_q.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_q_pkg.sv
// decode_stage_q_pkg
//   Shared definitions for the RV32I(+M) decode stage: one-hot bit indexes
//   for the ALU op, opcode class and exception vectors, the exact SYSTEM
//   encodings that raise exceptions, the major opcode enum and small
//   helpers that build one-hot ALU vectors.
package decode_stage_q_pkg;

    // ALU op one-hot indexes. M ops sit contiguously so that ALU_MUL + funct3
    // selects the right one.
    localparam int ALU_ADD    = 0;
    localparam int ALU_SUB    = 1;
    localparam int ALU_SLL    = 2;
    localparam int ALU_SLT    = 3;
    localparam int ALU_SLTU   = 4;
    localparam int ALU_XOR    = 5;
    localparam int ALU_SRL    = 6;
    localparam int ALU_SRA    = 7;
    localparam int ALU_OR     = 8;
    localparam int ALU_AND    = 9;
    localparam int ALU_EQ     = 10;
    localparam int ALU_NEQ    = 11;
    localparam int ALU_LT     = 12;
    localparam int ALU_GE     = 13;
    localparam int ALU_LTU    = 14;
    localparam int ALU_GEU    = 15;
    localparam int ALU_MUL    = 16;
    localparam int ALU_MULH   = 17;
    localparam int ALU_MULHSU = 18;
    localparam int ALU_MULHU  = 19;
    localparam int ALU_DIV    = 20;
    localparam int ALU_DIVU   = 21;
    localparam int ALU_REM    = 22;
    localparam int ALU_REMU   = 23;
    localparam int ALU_WIDTH  = 24;

    // Opcode class one-hot indexes.
    localparam int OPC_RTYPE    = 0;
    localparam int OPC_ITYPE    = 1;
    localparam int OPC_LOAD     = 2;
    localparam int OPC_STORE    = 3;
    localparam int OPC_BRANCH   = 4;
    localparam int OPC_JAL      = 5;
    localparam int OPC_JALR     = 6;
    localparam int OPC_LUI      = 7;
    localparam int OPC_AUIPC    = 8;
    localparam int OPC_SYSTEM   = 9;
    localparam int OPC_FENCE    = 10;
    localparam int OPCODE_WIDTH = 11;

    // Exception one-hot indexes.
    localparam int EXC_ILLEGAL = 0;
    localparam int EXC_ECALL   = 1;
    localparam int EXC_EBREAK  = 2;
    localparam int EXC_MRET    = 3;
    localparam int EXC_WIDTH   = 4;

    // Exact SYSTEM encodings; any other SYSTEM word raises nothing.
    localparam logic [31:0] ENC_ECALL  = 32'h0000_0073;
    localparam logic [31:0] ENC_EBREAK = 32'h0010_0073;
    localparam logic [31:0] ENC_MRET   = 32'h3020_0073;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_FENCE  = 7'b0001111,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_SYSTEM = 7'b1110011
    } opcode_e;

    function automatic logic [ALU_WIDTH-1:0] aluBit(input int idx);
        return ALU_WIDTH'(1) << idx;
    endfunction

    // Base integer op selected by funct3 (shifts default to the logical form).
    function automatic logic [ALU_WIDTH-1:0] baseAluOp(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return aluBit(ALU_ADD);
            3'b001:  return aluBit(ALU_SLL);
            3'b010:  return aluBit(ALU_SLT);
            3'b011:  return aluBit(ALU_SLTU);
            3'b100:  return aluBit(ALU_XOR);
            3'b101:  return aluBit(ALU_SRL);
            3'b110:  return aluBit(ALU_OR);
            default: return aluBit(ALU_AND);
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_q_fifo.sv
// decode_fifo
//   Circular instruction queue of DEPTH entries, each WIDTH bits wide.
//   Ports: d_clk/d_rst clock and async active-low reset; push_i/data_i write,
//   pop_i/head_o read (head is valid whenever empty_o is low); flush_i empties
//   the queue; full_o/empty_o/level_o report occupancy.
module decode_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic             d_clk,
    input  logic             d_rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [LW-1:0]    count_q, count_d;

    // Explicit wrap so that non-power-of-two depths work.
    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (push_i) wrPtr_d = nextPtr(wrPtr_q);
            if (pop_i)  rdPtr_d = nextPtr(rdPtr_q);
            if (push_i && !pop_i)      count_d = count_q + 1'b1;
            else if (pop_i && !push_i) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge d_clk or negedge d_rst) begin
        if (!d_rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while counted as occupied.
    always_ff @(posedge d_clk) begin
        if (push_i && !flush_i) mem_q[wrPtr_q] <= data_i;
    end

    assign head_o  = mem_q[rdPtr_q];
    assign full_o  = (count_q == LW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;

endmodule

// File: rtl/decode_stage_q.sv
// decode_stage_q
//   RV32I(+optional M) decode stage between fetch and execute. Instructions
//   are queued in decode_fifo and decoded from the queue head (or directly
//   from the input when the queue is empty and the output register is free),
//   then registered with field split, one-hot ALU/opcode class and exceptions.
//   Ports: d_clk/d_rst clock and async active-low reset; d_i_valid/d_o_ready
//   with d_i_instr/d_i_pc form the fetch handshake; d_o_valid/d_i_ready the
//   execute handshake; d_i_flush drops everything; d_o_* are the registered
//   decode results; d_o_level is queue occupancy.
module decode_stage_q
    import decode_stage_q_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int AWIDTH     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int ENABLE_M   = 0
) (
    input  logic                             d_clk,
    input  logic                             d_rst,
    input  logic                             d_i_valid,
    output logic                             d_o_ready,
    input  logic [31:0]                      d_i_instr,
    input  logic [PC_WIDTH-1:0]              d_i_pc,
    input  logic                             d_i_flush,
    output logic                             d_o_valid,
    input  logic                             d_i_ready,
    output logic [PC_WIDTH-1:0]              d_o_pc,
    output logic [AWIDTH-1:0]                d_o_rs1,
    output logic [AWIDTH-1:0]                d_o_rs2,
    output logic [AWIDTH-1:0]                d_o_rd,
    output logic [31:0]                      d_o_imm,
    output logic [2:0]                       d_o_funct3,
    output logic [ALU_WIDTH-1:0]             d_o_alu,
    output logic [OPCODE_WIDTH-1:0]          d_o_opcode,
    output logic [EXC_WIDTH-1:0]             d_o_exception,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  d_o_level
);

    localparam int LW      = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = PC_WIDTH + 32;

    logic               fifoFull, fifoEmpty, pushFifo, popFifo;
    logic [ENTRY_W-1:0] headEntry, selEntry;
    logic [31:0]        selInstr;
    logic [PC_WIDTH-1:0] selPc;
    logic               accept, outFree, bypass, loadOut;

    logic                    valid_q, valid_d;
    logic [PC_WIDTH-1:0]     pc_q;
    logic [AWIDTH-1:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [31:0]             imm_q, imm_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [ALU_WIDTH-1:0]    alu_q, alu_d;
    logic [OPCODE_WIDTH-1:0] opc_q, opc_d;
    logic [EXC_WIDTH-1:0]    exc_q, exc_d;

    decode_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W), .LW(LW)) u_fifo (
        .d_clk   (d_clk),
        .d_rst   (d_rst),
        .push_i  (pushFifo),
        .data_i  ({d_i_pc, d_i_instr}),
        .pop_i   (popFifo),
        .flush_i (d_i_flush),
        .head_o  (headEntry),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .level_o (d_o_level)
    );

    // Ready depends only on registered occupancy, so a pop while full does
    // not open the input in the same cycle. An empty queue with a free output
    // register lets the incoming instruction skip the queue; otherwise the
    // head is decoded and the new instruction queues behind it (FIFO order).
    assign d_o_ready = !fifoFull;
    assign accept    = d_i_valid && !fifoFull && !d_i_flush;
    assign outFree   = !valid_q || d_i_ready;
    assign bypass    = accept && fifoEmpty && outFree;
    assign loadOut   = !d_i_flush && outFree && (!fifoEmpty || bypass);
    assign popFifo   = !d_i_flush && outFree && !fifoEmpty;
    assign pushFifo  = accept && !bypass;
    assign selEntry  = fifoEmpty ? {d_i_pc, d_i_instr} : headEntry;
    assign selInstr  = selEntry[31:0];
    assign selPc     = selEntry[ENTRY_W-1:32];

    // Flush wins over everything; otherwise the register refills, empties
    // when consumed with nothing behind it, or holds under back-pressure.
    always_comb begin
        valid_d = valid_q;
        if (d_i_flush)    valid_d = 1'b0;
        else if (loadOut) valid_d = 1'b1;
        else if (outFree) valid_d = 1'b0;
    end

    // Decode of the selected entry. Fields absent from a format stay 0, and
    // an illegal word keeps only the ILLEGAL bit so nothing downstream acts
    // on a half-decoded instruction. Reserved branch funct3 values have no
    // comparison op and are treated as illegal.
    always_comb begin
        logic       illegal;
        logic [6:0] f7;
        logic [2:0] f3;
        logic [4:0] fRs1, fRs2, fRd;
        illegal  = 1'b0;
        f7       = selInstr[31:25];
        f3       = selInstr[14:12];
        fRs1     = '0;
        fRs2     = '0;
        fRd      = '0;
        imm_d    = '0;
        funct3_d = '0;
        alu_d    = aluBit(ALU_ADD);
        opc_d    = '0;
        exc_d    = '0;
        case (opcode_e'(selInstr[6:0]))
            OP_REG: begin
                opc_d[OPC_RTYPE] = 1'b1;
                {fRs1, fRs2, fRd} = {selInstr[19:15], selInstr[24:20], selInstr[11:7]};
                funct3_d = f3;
                if (f7 == 7'b0000000)
                    alu_d = baseAluOp(f3);
                else if (f7 == 7'b0100000 && f3 == 3'b000)
                    alu_d = aluBit(ALU_SUB);
                else if (f7 == 7'b0100000 && f3 == 3'b101)
                    alu_d = aluBit(ALU_SRA);
                else if (f7 == 7'b0000001 && ENABLE_M != 0)
                    alu_d = aluBit(ALU_MUL + int'(f3));
                else
                    illegal = 1'b1;
            end
            OP_IMM: begin
                opc_d[OPC_ITYPE] = 1'b1;
                {fRs1, fRd} = {selInstr[19:15], selInstr[11:7]};
                funct3_d = f3;
                imm_d    = {{20{selInstr[31]}}, selInstr[31:20]};
                alu_d    = baseAluOp(f3);
                if (f3 == 3'b001 && f7 != 7'b0000000) illegal = 1'b1;
                if (f3 == 3'b101) begin
                    if (f7 == 7'b0100000)      alu_d = aluBit(ALU_SRA);
                    else if (f7 != 7'b0000000) illegal = 1'b1;
                end
            end
            OP_LOAD, OP_JALR: begin
                opc_d[(selInstr[6:0] == OP_LOAD) ? OPC_LOAD : OPC_JALR] = 1'b1;
                {fRs1, fRd} = {selInstr[19:15], selInstr[11:7]};
                funct3_d = f3;
                imm_d    = {{20{selInstr[31]}}, selInstr[31:20]};
            end
            OP_STORE: begin
                opc_d[OPC_STORE] = 1'b1;
                {fRs1, fRs2} = {selInstr[19:15], selInstr[24:20]};
                funct3_d = f3;
                imm_d    = {{20{selInstr[31]}}, selInstr[31:25], selInstr[11:7]};
            end
            OP_BRANCH: begin
                opc_d[OPC_BRANCH] = 1'b1;
                {fRs1, fRs2} = {selInstr[19:15], selInstr[24:20]};
                funct3_d = f3;
                imm_d    = {{19{selInstr[31]}}, selInstr[31], selInstr[7],
                            selInstr[30:25], selInstr[11:8], 1'b0};
                case (f3)
                    3'b000:  alu_d = aluBit(ALU_EQ);
                    3'b001:  alu_d = aluBit(ALU_NEQ);
                    3'b100:  alu_d = aluBit(ALU_LT);
                    3'b101:  alu_d = aluBit(ALU_GE);
                    3'b110:  alu_d = aluBit(ALU_LTU);
                    3'b111:  alu_d = aluBit(ALU_GEU);
                    default: illegal = 1'b1;
                endcase
            end
            OP_JAL: begin
                opc_d[OPC_JAL] = 1'b1;
                fRd   = selInstr[11:7];
                imm_d = {{11{selInstr[31]}}, selInstr[31], selInstr[19:12],
                         selInstr[20], selInstr[30:21], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                opc_d[(selInstr[6:0] == OP_LUI) ? OPC_LUI : OPC_AUIPC] = 1'b1;
                fRd   = selInstr[11:7];
                imm_d = {selInstr[31:12], 12'b0};
            end
            OP_SYSTEM, OP_FENCE: begin
                opc_d[(selInstr[6:0] == OP_SYSTEM) ? OPC_SYSTEM : OPC_FENCE] = 1'b1;
                {fRs1, fRd} = {selInstr[19:15], selInstr[11:7]};
                funct3_d = f3;
                imm_d    = {20'b0, selInstr[31:20]};
                exc_d[EXC_ECALL]  = (selInstr == ENC_ECALL);
                exc_d[EXC_EBREAK] = (selInstr == ENC_EBREAK);
                exc_d[EXC_MRET]   = (selInstr == ENC_MRET);
            end
            default: illegal = 1'b1;
        endcase
        rs1_d = AWIDTH'(fRs1);
        rs2_d = AWIDTH'(fRs2);
        rd_d  = AWIDTH'(fRd);
        if (illegal) begin
            rs1_d    = '0;
            rs2_d    = '0;
            rd_d     = '0;
            imm_d    = '0;
            funct3_d = '0;
            alu_d    = '0;
            opc_d    = '0;
            exc_d    = '0;
            exc_d[EXC_ILLEGAL] = 1'b1;
        end
    end

    // Output register: loads only on a free slot, so data holds under stall.
    always_ff @(posedge d_clk or negedge d_rst) begin
        if (!d_rst) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            funct3_q <= '0;
            alu_q    <= '0;
            opc_q    <= '0;
            exc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            if (loadOut) begin
                pc_q     <= selPc;
                rs1_q    <= rs1_d;
                rs2_q    <= rs2_d;
                rd_q     <= rd_d;
                imm_q    <= imm_d;
                funct3_q <= funct3_d;
                alu_q    <= alu_d;
                opc_q    <= opc_d;
                exc_q    <= exc_d;
            end
        end
    end

    assign d_o_valid     = valid_q;
    assign d_o_pc        = pc_q;
    assign d_o_rs1       = rs1_q;
    assign d_o_rs2       = rs2_q;
    assign d_o_rd        = rd_q;
    assign d_o_imm       = imm_q;
    assign d_o_funct3    = funct3_q;
    assign d_o_alu       = alu_q;
    assign d_o_opcode    = opc_q;
    assign d_o_exception = exc_q;

endmodule

// File: tb/tb_decode_stage_q.sv
// tb_decode_stage_q
//   Directed bench for decode_stage_q. Two instances share all inputs: one
//   with the M extension disabled (main checks) and one with it enabled.
module tb_decode_stage_q;
    import decode_stage_q_pkg::*;

    logic        d_clk = 1'b0;
    logic        d_rst = 1'b0;
    logic        d_i_valid = 1'b0, d_i_ready = 1'b0, d_i_flush = 1'b0;
    logic [31:0] d_i_instr = '0, d_i_pc = '0;

    logic        d_o_ready, d_o_valid;
    logic [31:0] d_o_pc, d_o_imm;
    logic [4:0]  d_o_rs1, d_o_rs2, d_o_rd;
    logic [2:0]  d_o_funct3;
    logic [ALU_WIDTH-1:0]    d_o_alu;
    logic [OPCODE_WIDTH-1:0] d_o_opcode;
    logic [EXC_WIDTH-1:0]    d_o_exception;
    logic [1:0]  d_o_level;

    logic        m_ready, m_valid;
    logic [31:0] m_pc, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [2:0]  m_funct3;
    logic [ALU_WIDTH-1:0]    m_alu;
    logic [OPCODE_WIDTH-1:0] m_opcode;
    logic [EXC_WIDTH-1:0]    m_exception;
    logic [1:0]  m_level;

    int checks = 0;
    int errors = 0;

    always #5 d_clk = ~d_clk;

    decode_stage_q #(.PC_WIDTH(32), .AWIDTH(5), .FIFO_DEPTH(2), .ENABLE_M(0)) dut (
        .d_clk(d_clk), .d_rst(d_rst), .d_i_valid(d_i_valid), .d_o_ready(d_o_ready),
        .d_i_instr(d_i_instr), .d_i_pc(d_i_pc), .d_i_flush(d_i_flush),
        .d_o_valid(d_o_valid), .d_i_ready(d_i_ready), .d_o_pc(d_o_pc),
        .d_o_rs1(d_o_rs1), .d_o_rs2(d_o_rs2), .d_o_rd(d_o_rd), .d_o_imm(d_o_imm),
        .d_o_funct3(d_o_funct3), .d_o_alu(d_o_alu), .d_o_opcode(d_o_opcode),
        .d_o_exception(d_o_exception), .d_o_level(d_o_level)
    );

    decode_stage_q #(.PC_WIDTH(32), .AWIDTH(5), .FIFO_DEPTH(2), .ENABLE_M(1)) dutM (
        .d_clk(d_clk), .d_rst(d_rst), .d_i_valid(d_i_valid), .d_o_ready(m_ready),
        .d_i_instr(d_i_instr), .d_i_pc(d_i_pc), .d_i_flush(d_i_flush),
        .d_o_valid(m_valid), .d_i_ready(d_i_ready), .d_o_pc(m_pc),
        .d_o_rs1(m_rs1), .d_o_rs2(m_rs2), .d_o_rd(m_rd), .d_o_imm(m_imm),
        .d_o_funct3(m_funct3), .d_o_alu(m_alu), .d_o_opcode(m_opcode),
        .d_o_exception(m_exception), .d_o_level(m_level)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                                 input logic [31:0] pc, input logic ready,
                                 input logic flush);
        d_i_valid = valid;
        d_i_instr = instr;
        d_i_pc    = pc;
        d_i_ready = ready;
        d_i_flush = flush;
    endtask

    task automatic step();
        @(posedge d_clk);
        #1;
    endtask

    function automatic logic [63:0] bitAt(input int idx);
        return 64'(1) << idx;
    endfunction

    // Full decode comparison of the main instance.
    task automatic expectDecode(input string tag, input logic [31:0] pc,
                                input logic [63:0] opc, input logic [63:0] alu,
                                input logic [31:0] imm, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [63:0] exc);
        checkOutput({tag, ".valid"}, 64'(d_o_valid), 64'd1);
        checkOutput({tag, ".pc"},    64'(d_o_pc), 64'(pc));
        checkOutput({tag, ".opc"},   64'(d_o_opcode), opc);
        checkOutput({tag, ".alu"},   64'(d_o_alu), alu);
        checkOutput({tag, ".imm"},   64'(d_o_imm), 64'(imm));
        checkOutput({tag, ".rs1"},   64'(d_o_rs1), 64'(rs1));
        checkOutput({tag, ".rs2"},   64'(d_o_rs2), 64'(rs2));
        checkOutput({tag, ".rd"},    64'(d_o_rd), 64'(rd));
        checkOutput({tag, ".exc"},   64'(d_o_exception), exc);
    endtask

    initial begin
        $display("[TB] start");
        // Reset state
        repeat (2) @(posedge d_clk);
        #1;
        checkOutput("rst.valid", 64'(d_o_valid), 64'd0);
        checkOutput("rst.level", 64'(d_o_level), 64'd0);
        checkOutput("rst.ready", 64'(d_o_ready), 64'd1);
        checkOutput("rst.pc",    64'(d_o_pc), 64'd0);
        checkOutput("rst.alu",   64'(d_o_alu), 64'd0);
        checkOutput("rst.opc",   64'(d_o_opcode), 64'd0);
        d_rst = 1'b1;
        step();

        // 1. Stream with latency 1
        applyStimulus(1, 32'h0050_0093, 32'h0, 1, 0);
        step();
        expectDecode("addi", 32'h0, bitAt(OPC_ITYPE), bitAt(ALU_ADD), 32'd5, 5'd0, 5'd0, 5'd1, 64'd0);
        applyStimulus(1, 32'h0020_81B3, 32'h4, 1, 0);
        step();
        expectDecode("add", 32'h4, bitAt(OPC_RTYPE), bitAt(ALU_ADD), 32'd0, 5'd1, 5'd2, 5'd3, 64'd0);

        // 4. Exceptions
        applyStimulus(1, 32'h0000_0073, 32'h8, 1, 0);
        step();
        expectDecode("ecall", 32'h8, bitAt(OPC_SYSTEM), bitAt(ALU_ADD), 32'd0, 5'd0, 5'd0, 5'd0, bitAt(EXC_ECALL));
        applyStimulus(1, 32'h0010_0073, 32'hC, 1, 0);
        step();
        expectDecode("ebreak", 32'hC, bitAt(OPC_SYSTEM), bitAt(ALU_ADD), 32'd1, 5'd0, 5'd0, 5'd0, bitAt(EXC_EBREAK));
        applyStimulus(1, 32'h3020_0073, 32'h10, 1, 0);
        step();
        expectDecode("mret", 32'h10, bitAt(OPC_SYSTEM), bitAt(ALU_ADD), 32'h302, 5'd0, 5'd0, 5'd0, bitAt(EXC_MRET));
        applyStimulus(1, 32'hFFFF_FFFF, 32'h14, 1, 0);
        step();
        expectDecode("allones", 32'h14, 64'd0, 64'd0, 32'd0, 5'd0, 5'd0, 5'd0, bitAt(EXC_ILLEGAL));

        // 5. mul with and without the M extension
        applyStimulus(1, 32'h0273_02B3, 32'h18, 1, 0);
        step();
        expectDecode("mul.noM", 32'h18, 64'd0, 64'd0, 32'd0, 5'd0, 5'd0, 5'd0, bitAt(EXC_ILLEGAL));
        checkOutput("mul.M.valid", 64'(m_valid), 64'd1);
        checkOutput("mul.M.opc",   64'(m_opcode), bitAt(OPC_RTYPE));
        checkOutput("mul.M.alu",   64'(m_alu), bitAt(ALU_MUL));
        checkOutput("mul.M.exc",   64'(m_exception), 64'd0);
        checkOutput("mul.M.regs",  {49'd0, m_rs1, m_rs2, m_rd}, {49'd0, 5'd6, 5'd7, 5'd5});

        // 6. Branch / immediate corners and shift-immediate funct7 rules
        applyStimulus(1, 32'hFE00_0EE3, 32'h1C, 1, 0);
        step();
        expectDecode("beq", 32'h1C, bitAt(OPC_BRANCH), bitAt(ALU_EQ), 32'hFFFF_FFFC, 5'd0, 5'd0, 5'd0, 64'd0);
        applyStimulus(1, 32'hFFFF_F0B7, 32'h20, 1, 0);
        step();
        expectDecode("lui", 32'h20, bitAt(OPC_LUI), bitAt(ALU_ADD), 32'hFFFF_F000, 5'd0, 5'd0, 5'd1, 64'd0);
        applyStimulus(1, 32'h4031_5093, 32'h24, 1, 0);
        step();
        expectDecode("srai", 32'h24, bitAt(OPC_ITYPE), bitAt(ALU_SRA), 32'h403, 5'd2, 5'd0, 5'd1, 64'd0);
        applyStimulus(1, 32'h4031_1093, 32'h28, 1, 0);
        step();
        expectDecode("slli.bad", 32'h28, 64'd0, 64'd0, 32'd0, 5'd0, 5'd0, 5'd0, bitAt(EXC_ILLEGAL));
        applyStimulus(0, 32'h0, 32'h0, 1, 0);
        step();
        checkOutput("idle.valid", 64'(d_o_valid), 64'd0);

        // 2. Back-pressure with depth 2
        applyStimulus(1, 32'h0010_0093, 32'h40, 0, 0);
        step();
        checkOutput("bp.a.pc",    64'(d_o_pc), 64'h40);
        checkOutput("bp.a.level", 64'(d_o_level), 64'd0);
        applyStimulus(1, 32'h0020_0113, 32'h44, 0, 0);
        step();
        checkOutput("bp.b.level", 64'(d_o_level), 64'd1);
        checkOutput("bp.b.ready", 64'(d_o_ready), 64'd1);
        applyStimulus(1, 32'h0030_0193, 32'h48, 0, 0);
        step();
        checkOutput("bp.c.level", 64'(d_o_level), 64'd2);
        checkOutput("bp.c.ready", 64'(d_o_ready), 64'd0);
        applyStimulus(1, 32'h0040_0213, 32'h4C, 0, 0);
        step();
        checkOutput("bp.hold.level", 64'(d_o_level), 64'd2);
        checkOutput("bp.hold.pc",    64'(d_o_pc), 64'h40);
        checkOutput("bp.hold.rd",    64'(d_o_rd), 64'd1);
        checkOutput("bp.hold.imm",   64'(d_o_imm), 64'd1);
        checkOutput("bp.hold.valid", 64'(d_o_valid), 64'd1);
        applyStimulus(0, 32'h0, 32'h0, 1, 0);
        step();
        checkOutput("bp.drain1.pc",    64'(d_o_pc), 64'h44);
        checkOutput("bp.drain1.rd",    64'(d_o_rd), 64'd2);
        checkOutput("bp.drain1.level", 64'(d_o_level), 64'd1);
        step();
        checkOutput("bp.drain2.pc",    64'(d_o_pc), 64'h48);
        checkOutput("bp.drain2.rd",    64'(d_o_rd), 64'd3);
        checkOutput("bp.drain2.level", 64'(d_o_level), 64'd0);
        step();
        checkOutput("bp.empty.valid", 64'(d_o_valid), 64'd0);

        // 3. Flush while full, output valid and an instruction offered
        applyStimulus(1, 32'h0010_0093, 32'h60, 0, 0);
        step();
        applyStimulus(1, 32'h0020_0113, 32'h64, 0, 0);
        step();
        applyStimulus(1, 32'h0030_0193, 32'h68, 0, 0);
        step();
        checkOutput("fl.pre.level", 64'(d_o_level), 64'd2);
        checkOutput("fl.pre.valid", 64'(d_o_valid), 64'd1);
        applyStimulus(1, 32'h0050_0293, 32'h6C, 0, 1);
        step();
        checkOutput("fl.valid", 64'(d_o_valid), 64'd0);
        checkOutput("fl.level", 64'(d_o_level), 64'd0);
        checkOutput("fl.ready", 64'(d_o_ready), 64'd1);
        applyStimulus(0, 32'h0, 32'h0, 1, 0);
        step();
        checkOutput("fl.post1.valid", 64'(d_o_valid), 64'd0);
        step();
        checkOutput("fl.post2.valid", 64'(d_o_valid), 64'd0);
        checkOutput("fl.post2.level", 64'(d_o_level), 64'd0);

        // Reset in the middle of a transfer drops everything
        applyStimulus(1, 32'h0010_0093, 32'h80, 0, 0);
        step();
        applyStimulus(1, 32'h0020_0113, 32'h84, 0, 0);
        step();
        checkOutput("mr.pre.level", 64'(d_o_level), 64'd1);
        d_rst = 1'b0;
        #2;
        checkOutput("mr.valid", 64'(d_o_valid), 64'd0);
        checkOutput("mr.level", 64'(d_o_level), 64'd0);
        checkOutput("mr.pc",    64'(d_o_pc), 64'd0);
        applyStimulus(0, 32'h0, 32'h0, 1, 0);
        step();
        d_rst = 1'b1;
        step();
        checkOutput("mr.post.valid", 64'(d_o_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
